// File: rtl/dispatcher_pkg.sv
// Shared constants and types for the dispatcher packet scheduler.
package dispatcher_pkg;

  localparam int unsigned PKT_W = 134;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic {
    ARB,
    XFER
  } state_e;

endpackage

// File: rtl/dispatcher_pkt_sched_if.sv
// RDMA write-side bundle: packet words, packet flag and almost-full back-pressure.
interface dispatcher_pkt_sched_if;

  logic                            out_rdma_pkt_wr;
  logic [dispatcher_pkg::PKT_W-1:0] out_rdma_pkt;
  logic                            out_rdma_valid_wr;
  logic                            out_rdma_valid;
  logic                            in_rdma_pkt_almostfull;

  modport master (
    output out_rdma_pkt_wr,
    output out_rdma_pkt,
    output out_rdma_valid_wr,
    output out_rdma_valid,
    input  in_rdma_pkt_almostfull
  );

  modport slave (
    input  out_rdma_pkt_wr,
    input  out_rdma_pkt,
    input  out_rdma_valid_wr,
    input  out_rdma_valid,
    output in_rdma_pkt_almostfull
  );

endinterface

// File: rtl/dispatcher_rr_pick.sv
// Rotating-priority first-one finder: first set request at or after start_i, wrapping.
module dispatcher_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic [IdxW-1:0] idx_o,
  output logic            found_o
);

  logic [N-1:0] rot;

  // Rotate so that bit 0 corresponds to the start pointer.
  assign rot = N'({req_i, req_i} >> start_i);

  always_comb begin
    int unsigned sum;
    sum     = 0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found_o && rot[i]) begin
        sum = 32'(start_i) + i;
        if (sum >= N) sum = sum - N;
        idx_o   = IdxW'(sum);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispatcher_pkt_sched.sv
// Packet-granular weighted round-robin scheduler feeding the RDMA write port.
// Optional per-port discard counters when DISPATCH_DROP_CNT_EN is defined.
module dispatcher_pkt_sched import dispatcher_pkg::*; #(
  parameter int unsigned NPORT    = 4,
  parameter int unsigned WEIGHT_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPORT-1:0]          in_flag_empty,
  input  logic [NPORT-1:0]          in_flag_q,
  output logic [NPORT-1:0]          out_flag_rd,
  input  logic [NPORT*PKT_W-1:0]    in_pkt_q,
  output logic [NPORT-1:0]          out_pkt_rd,
  input  logic [NPORT*WEIGHT_W-1:0] in_weight,
  dispatcher_pkt_sched_if.master    rdma_io,
  output logic [2:0]                out_grant,
  output logic                      out_busy
`ifdef DISPATCH_DROP_CNT_EN
  ,
  output logic [NPORT*16-1:0]       out_drop_cnt
`endif
);

  localparam int unsigned PortW = $clog2(NPORT);

  state_e              state_q, state_d;
  logic [PortW-1:0]    cur_q, cur_d;
  logic [WEIGHT_W-1:0] credit_q [NPORT];
  logic [WEIGHT_W-1:0] credit_d [NPORT];
  logic [WEIGHT_W-1:0] reload   [NPORT];
  logic [WEIGHT_W-1:0] eff      [NPORT];
  logic [NPORT-1:0]    fresh_q, fresh_d;
  logic                keep_q, keep_d, keep_now;
  logic                first_q, first_d;
  logic [PKT_W-1:0]    pkt_q, pkt_d;
  logic                pkt_wr_q, pkt_wr_d;
  logic                vwr_q, vwr_d;
  logic [NPORT-1:0]    avail;
  logic [PortW-1:0]    start, pick_idx;
  logic                pick_found;
  logic [PKT_W-1:0]    word;
`ifdef DISPATCH_DROP_CNT_EN
  logic [15:0]         drop_q [NPORT];
  logic [15:0]         drop_d [NPORT];
`endif

  assign avail = ~in_flag_empty;
  assign start = (cur_q == PortW'(NPORT - 1)) ? '0 : cur_q + 1'b1;
  assign word  = in_pkt_q[cur_q * PKT_W +: PKT_W];

  // fresh_q marks credits not yet loaded since reset; they read as the current weight.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      reload[i] = in_weight[i * WEIGHT_W +: WEIGHT_W];
      if (reload[i] == '0) reload[i] = WEIGHT_W'(1);
      eff[i] = fresh_q[i] ? reload[i] : credit_q[i];
    end
  end

  dispatcher_rr_pick #(
    .N    (NPORT),
    .IdxW (PortW)
  ) u_rr_pick (
    .req_i   (avail),
    .start_i (start),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    credit_d    = credit_q;
    fresh_d     = fresh_q;
    keep_d      = keep_q;
    keep_now    = keep_q;
    first_d     = 1'b0;
    pkt_d       = pkt_q;
    pkt_wr_d    = 1'b0;
    vwr_d       = 1'b0;
    out_flag_rd = '0;
    out_pkt_rd  = '0;
`ifdef DISPATCH_DROP_CNT_EN
    drop_d      = drop_q;
`endif
    unique case (state_q)
      ARB: begin
        if (!rdma_io.in_rdma_pkt_almostfull && pick_found) begin
          if (!(avail[cur_q] && eff[cur_q] != '0)) begin
            credit_d[cur_q] = reload[cur_q];
            fresh_d[cur_q]  = 1'b0;
            cur_d           = pick_idx;
          end
          state_d = XFER;
          first_d = 1'b1;
        end
      end
      XFER: begin
        out_pkt_rd[cur_q] = 1'b1;
        if (first_q) begin
          out_flag_rd[cur_q] = 1'b1;
          keep_now           = in_flag_q[cur_q];
          keep_d             = keep_now;
        end
        if (keep_now) begin
          pkt_d    = word;
          pkt_wr_d = 1'b1;
        end
        // Discarded packets consume credit just like forwarded ones.
        if (word[PKT_W-1 -: 2] == HDR_TAIL) begin
          vwr_d           = keep_now;
          state_d         = ARB;
          credit_d[cur_q] = (eff[cur_q] == '0) ? '0 : eff[cur_q] - 1'b1;
          fresh_d[cur_q]  = 1'b0;
`ifdef DISPATCH_DROP_CNT_EN
          if (!keep_now && drop_q[cur_q] != 16'hFFFF) drop_d[cur_q] = drop_q[cur_q] + 16'd1;
`endif
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB;
      cur_q    <= '0;
      fresh_q  <= '1;
      keep_q   <= 1'b0;
      first_q  <= 1'b0;
      pkt_q    <= '0;
      pkt_wr_q <= 1'b0;
      vwr_q    <= 1'b0;
      for (int i = 0; i < NPORT; i++) begin
        credit_q[i] <= '0;
`ifdef DISPATCH_DROP_CNT_EN
        drop_q[i]   <= '0;
`endif
      end
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      fresh_q  <= fresh_d;
      keep_q   <= keep_d;
      first_q  <= first_d;
      pkt_q    <= pkt_d;
      pkt_wr_q <= pkt_wr_d;
      vwr_q    <= vwr_d;
      credit_q <= credit_d;
`ifdef DISPATCH_DROP_CNT_EN
      drop_q   <= drop_d;
`endif
    end
  end

  assign rdma_io.out_rdma_pkt_wr   = pkt_wr_q;
  assign rdma_io.out_rdma_pkt      = pkt_q;
  assign rdma_io.out_rdma_valid_wr = vwr_q;
  assign rdma_io.out_rdma_valid    = vwr_q;
  assign out_grant                 = 3'(cur_q);
  assign out_busy                  = (state_q == XFER);

`ifdef DISPATCH_DROP_CNT_EN
  for (genvar g = 0; g < NPORT; g++) begin : g_drop
    assign out_drop_cnt[16*g +: 16] = drop_q[g];
  end
`endif

endmodule

// File: tb/tb_dispatcher_pkt_sched.sv
// Directed bench for dispatcher_pkt_sched with show-ahead FIFO models per port.
module tb_dispatcher_pkt_sched;
  import dispatcher_pkg::*;

  localparam int NP = 4;
  localparam int WW = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NP-1:0]        in_flag_empty;
  logic [NP-1:0]        in_flag_q;
  logic [NP-1:0]        out_flag_rd;
  logic [NP*PKT_W-1:0]  in_pkt_q;
  logic [NP-1:0]        out_pkt_rd;
  logic [NP*WW-1:0]     in_weight;
  logic [2:0]           out_grant;
  logic                 out_busy;
`ifdef DISPATCH_DROP_CNT_EN
  logic [NP*16-1:0]     out_drop_cnt;
`endif

  always #5 clk = ~clk;

  dispatcher_pkt_sched_if rdma_if ();

  dispatcher_pkt_sched #(
    .NPORT    (NP),
    .WEIGHT_W (WW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_flag_empty (in_flag_empty),
    .in_flag_q     (in_flag_q),
    .out_flag_rd   (out_flag_rd),
    .in_pkt_q      (in_pkt_q),
    .out_pkt_rd    (out_pkt_rd),
    .in_weight     (in_weight),
    .rdma_io       (rdma_if),
    .out_grant     (out_grant),
    .out_busy      (out_busy)
`ifdef DISPATCH_DROP_CNT_EN
    ,
    .out_drop_cnt  (out_drop_cnt)
`endif
  );

  logic [PKT_W-1:0] pmem [NP][64];
  logic             fmem [NP][64];
  int prd [NP];
  int pwr [NP];
  int frd [NP];
  int fwr [NP];
  int fpop [NP];
  int ppop [NP];
  int glog [$];
  int total = 0;
  int bad = 0;
  int tick_n, wr_cnt, vwr_cnt, valid_cnt, first_wr, last_wr, vwr_tick;
  logic prev_busy;
  logic [PKT_W-1:0] last_word;

  function automatic logic [PKT_W-1:0] mkword(logic [1:0] h, logic [7:0] tag, logic [7:0] idx);
    return {h, 116'(0), tag, idx};
  endfunction

  function automatic int gl(int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      in_flag_empty[p]             = (frd[p] == fwr[p]);
      in_flag_q[p]                 = fmem[p][frd[p] % 64];
      in_pkt_q[p*PKT_W +: PKT_W]   = pmem[p][prd[p] % 64];
    end
  endtask

  task automatic fifo_clear();
    for (int p = 0; p < NP; p++) begin
      prd[p] = 0; pwr[p] = 0; frd[p] = 0; fwr[p] = 0;
      for (int k = 0; k < 64; k++) begin
        pmem[p][k] = '0;
        fmem[p][k] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic push_pkt(input int p, input int len, input logic flag, input logic [7:0] tag);
    logic [1:0] h;
    for (int i = 0; i < len; i++) begin
      h = (i == 0) ? HDR_HEAD : ((i == len - 1) ? HDR_TAIL : HDR_MID);
      pmem[p][pwr[p] % 64] = mkword(h, tag, 8'(i));
      pwr[p]++;
    end
    fmem[p][fwr[p] % 64] = flag;
    fwr[p]++;
    drive();
  endtask

  task automatic clr();
    tick_n = 0; wr_cnt = 0; vwr_cnt = 0; valid_cnt = 0;
    first_wr = -1; last_wr = -1; vwr_tick = -1; last_word = '0;
    for (int p = 0; p < NP; p++) begin
      fpop[p] = 0; ppop[p] = 0;
    end
    glog.delete();
    prev_busy = out_busy;
  endtask

  // Pops are sampled mid-cycle and applied just after the edge, like a show-ahead FIFO.
  task automatic tick();
    logic [NP-1:0] fr, pr;
    @(negedge clk);
    fr = out_flag_rd;
    pr = out_pkt_rd;
    @(posedge clk);
    #1;
    tick_n++;
    for (int p = 0; p < NP; p++) begin
      if (fr[p]) begin frd[p]++; fpop[p]++; end
      if (pr[p]) begin prd[p]++; ppop[p]++; end
    end
    drive();
    if (rdma_if.out_rdma_pkt_wr) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = tick_n;
      last_wr   = tick_n;
      last_word = rdma_if.out_rdma_pkt;
    end
    if (rdma_if.out_rdma_valid_wr) begin
      vwr_cnt++;
      vwr_tick = tick_n;
    end
    if (rdma_if.out_rdma_valid) valid_cnt++;
    if (out_busy && !prev_busy) glog.push_back(int'(out_grant));
    prev_busy = out_busy;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fifo_clear();
    tick();
    reset = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wr"},    rdma_if.out_rdma_pkt_wr, 0);
    chk({tag, "_pkt"},   rdma_if.out_rdma_pkt, 0);
    chk({tag, "_vwr"},   rdma_if.out_rdma_valid_wr, 0);
    chk({tag, "_valid"}, rdma_if.out_rdma_valid, 0);
    chk({tag, "_grant"}, out_grant, 0);
    chk({tag, "_busy"},  out_busy, 0);
    chk({tag, "_frd"},   out_flag_rd, 0);
    chk({tag, "_prd"},   out_pkt_rd, 0);
  endtask

  initial begin
    int exp3 [12];
    exp3 = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    reset = 1'b1;
    rdma_if.in_rdma_pkt_almostfull = 1'b0;
    in_weight = 16'h0112;  // w0=2 w1=1 w2=1 w3=0
    fifo_clear();
    #1 reset = 1'b0;
    #1 chk_idle("rst");
    tick();
    reset = 1'b1;

    // Single forwarded 4-word packet on port 0.
    clr();
    push_pkt(0, 4, 1'b1, 8'hA1);
    run(8);
    chk("t1_wr_cnt", wr_cnt, 4);
    chk("t1_first_wr", first_wr, 2);
    chk("t1_last_wr", last_wr, 5);
    chk("t1_vwr_tick", vwr_tick, 5);
    chk("t1_vwr_cnt", vwr_cnt, 1);
    chk("t1_valid_cnt", valid_cnt, 1);
    chk("t1_tail_word", last_word, mkword(HDR_TAIL, 8'hA1, 8'd3));
    chk("t1_grant", gl(0), 0);
    chk("t1_ppop", ppop[0], 4);
    chk("t1_fpop", fpop[0], 1);

    // Discarded 3-word packet on port 1.
    do_reset();
    clr();
    push_pkt(1, 3, 1'b0, 8'hB2);
    run(8);
    chk("t2_wr_cnt", wr_cnt, 0);
    chk("t2_vwr_cnt", vwr_cnt, 0);
    chk("t2_ppop", ppop[1], 3);
    chk("t2_fpop", fpop[1], 1);
    chk("t2_grant", gl(0), 1);
`ifdef DISPATCH_DROP_CNT_EN
    chk("t2_drop1", out_drop_cnt[31:16], 1);
`endif

    // Weighted round robin, port 0 weight 2, port 1 weight 1.
    do_reset();
    clr();
    for (int k = 0; k < 6; k++) begin
      push_pkt(0, 2, 1'b1, 8'(k));
      push_pkt(1, 2, 1'b1, 8'(16 + k));
    end
    run(45);
    chk("t3_ngrant", glog.size(), 12);
    for (int i = 0; i < 12; i++) chk($sformatf("t3_grant%0d", i), gl(i), exp3[i]);
    chk("t3_wr_cnt", wr_cnt, 24);
    chk("t3_vwr_cnt", vwr_cnt, 12);

    // Almost-full at arbitration blocks the grant.
    do_reset();
    clr();
    rdma_if.in_rdma_pkt_almostfull = 1'b1;
    push_pkt(2, 2, 1'b1, 8'hC3);
    run(5);
    chk("t4_blk_ppop", ppop[2], 0);
    chk("t4_blk_fpop", fpop[2], 0);
    chk("t4_blk_ngrant", glog.size(), 0);
    rdma_if.in_rdma_pkt_almostfull = 1'b0;
    run(6);
    chk("t4_rel_fpop", fpop[2], 1);
    chk("t4_rel_wr", wr_cnt, 2);

    // Almost-full mid-packet is ignored.
    clr();
    push_pkt(0, 8, 1'b1, 8'hD4);
    run(2);
    rdma_if.in_rdma_pkt_almostfull = 1'b1;
    run(12);
    chk("t4_mid_wr", wr_cnt, 8);
    chk("t4_mid_vwr", vwr_cnt, 1);
    chk("t4_mid_tail", last_word, mkword(HDR_TAIL, 8'hD4, 8'd7));
    rdma_if.in_rdma_pkt_almostfull = 1'b0;

    // Only port 3 active; pointer parks at 3 with spent credit, then wraps back to 3.
    do_reset();
    clr();
    push_pkt(3, 2, 1'b1, 8'hE5);
    run(5);
    push_pkt(3, 2, 1'b1, 8'hE6);
    run(5);
    chk("t5_ngrant", glog.size(), 2);
    chk("t5_grant0", gl(0), 3);
    chk("t5_grant1", gl(1), 3);
    chk("t5_wr", wr_cnt, 4);

    // Reset in the middle of a transfer.
    do_reset();
    clr();
    push_pkt(0, 2, 1'b1, 8'hF0);
    push_pkt(0, 8, 1'b1, 8'hF1);
    run(6);
    chk("t6_busy_pre", out_busy, 1);
    chk("t6_wr_pre", rdma_if.out_rdma_pkt_wr, 1);
    reset = 1'b0;
    #1 chk_idle("t6_rst");
    fifo_clear();
    tick();
    reset = 1'b1;
    clr();
    push_pkt(0, 2, 1'b1, 8'hF2);
    push_pkt(0, 2, 1'b1, 8'hF3);
    push_pkt(1, 2, 1'b1, 8'hF4);
    run(15);
    chk("t6_ngrant", glog.size(), 3);
    chk("t6_grant0", gl(0), 0);
    chk("t6_grant1", gl(1), 0);
    chk("t6_grant2", gl(2), 1);
    chk("t6_wr", wr_cnt, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
